// File: rtl/batchnorm_pkg.sv
// Shared types and helpers for the batchnorm layer.
// FSM encoding plus a generic signed saturator.
package batchnorm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/batchnorm_layer_fixed_mul_add_sat.sv
// Combinational datapath: x*scale product for stage 1,
// then shift, bias add and saturation for stage 2.
module fixed_mul_add_sat
  import batchnorm_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int NFRAC      = 5,
  parameter int COEF_WIDTH = 16,
  localparam int PW        = WIDTH + COEF_WIDTH
) (
  input  logic signed [WIDTH-1:0]      x,
  input  logic signed [COEF_WIDTH-1:0] scale,
  output logic signed [PW-1:0]         product,
  input  logic signed [PW-1:0]         prod_q,
  input  logic signed [WIDTH-1:0]      bias,
  output logic signed [WIDTH-1:0]      result
);

  localparam int SW = PW + 1;

  logic signed [SW-1:0] sum;

  // Full-width product and one guard bit on the sum keep
  // every value exact until the final clamp.
  assign product = PW'(x) * PW'(scale);
  assign sum     = SW'(prod_q >>> NFRAC) + SW'(bias);
  assign result  = WIDTH'(saturate(64'(sum), WIDTH));

endmodule

// File: rtl/batchnorm_layer.sv
// Per-element affine normalisation y = sat((x*scale >>> NFRAC) + bias)
// over a SIZE-element vector, one element per cycle, two stages.
module batchnorm_layer
  import batchnorm_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int NFRAC      = 5,
  parameter int SIZE       = 32,
  parameter int COEF_WIDTH = 16,
  localparam int AW        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [WIDTH-1:0]      input_data [SIZE],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [WIDTH-1:0]      output_data [SIZE],
  input  logic                         coef_wr_en,
  input  logic [AW-1:0]                coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_scale,
  input  logic signed [WIDTH-1:0]      coef_bias
);

  localparam int PW = WIDTH + COEF_WIDTH;
  localparam logic [AW-1:0] KLAST = AW'(SIZE - 1);
  localparam logic signed [COEF_WIDTH-1:0] ONE =
    COEF_WIDTH'(1 << NFRAC);

  state_t state, nxt;

  logic [AW-1:0]               k;
  logic signed [WIDTH-1:0]     x_buf [SIZE];
  logic signed [COEF_WIDTH-1:0] scale [SIZE];
  logic signed [WIDTH-1:0]     bias [SIZE];
  logic signed [PW-1:0]        p_q;
  logic [AW-1:0]               p_idx;
  logic                        p_vld;
  logic                        last_wr;
  logic signed [PW-1:0]        product;
  logic signed [WIDTH-1:0]     result;
  logic                        accept;
  logic                        coef_ok;

  assign accept  = (state == IDLE) && in_valid;
  assign coef_ok = (state == IDLE) && coef_wr_en &&
                   ({{(32-AW){1'b0}}, coef_addr} < 32'(SIZE));

  fixed_mul_add_sat #(
    .WIDTH(WIDTH),
    .NFRAC(NFRAC),
    .COEF_WIDTH(COEF_WIDTH)
  ) u_dp (
    .x(x_buf[k]),
    .scale(scale[k]),
    .product(product),
    .prod_q(p_q),
    .bias(bias[p_idx]),
    .result(result)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = RUN;
      end
      RUN: begin
        if (k == KLAST) nxt = DRAIN;
      end
      DRAIN: begin
        if (last_wr) nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Coefficient table, writable only while idle; identity on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        scale[i] <= ONE;
        bias[i]  <= '0;
      end
    end else if (coef_ok) begin
      scale[coef_addr] <= coef_scale;
      bias[coef_addr]  <= coef_bias;
    end
  end

  // Input capture, issue index and the two pipeline stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= '0;
      p_q     <= '0;
      p_idx   <= '0;
      p_vld   <= 1'b0;
      last_wr <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        x_buf[i]       <= '0;
        output_data[i] <= '0;
      end
    end else begin
      p_vld   <= (state == RUN);
      last_wr <= p_vld && (p_idx == KLAST);
      if (accept) begin
        x_buf <= input_data;
        k     <= '0;
      end
      if (state == RUN) begin
        p_q   <= product;
        p_idx <= k;
        if (k != KLAST) k <= k + 1'b1;
      end
      if (p_vld) output_data[p_idx] <= result;
    end
  end

endmodule

// File: tb/tb_batchnorm_layer.sv
// Directed and randomized checks of batchnorm_layer
// against a plain-arithmetic reference model.
module tb_batchnorm_layer;

  localparam int WIDTH = 10;
  localparam int NFRAC = 5;
  localparam int SIZE  = 32;
  localparam int CW    = 16;
  localparam int AW    = 5;
  localparam int LAT   = SIZE + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [WIDTH-1:0] in_data [SIZE];
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [WIDTH-1:0] out_data [SIZE];
  logic coef_wr_en = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic signed [CW-1:0] coef_scale = '0;
  logic signed [WIDTH-1:0] coef_bias = '0;

  int tests = 0;
  int fails = 0;
  int m_scale [SIZE];
  int m_bias [SIZE];
  int xv [SIZE];

  batchnorm_layer #(
    .WIDTH(WIDTH),
    .NFRAC(NFRAC),
    .SIZE(SIZE),
    .COEF_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .input_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .output_data(out_data),
    .coef_wr_en(coef_wr_en),
    .coef_addr(coef_addr),
    .coef_scale(coef_scale),
    .coef_bias(coef_bias)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int x, input int i);
    int p, q, d;
    d = 1 << NFRAC;
    p = x * m_scale[i];
    q = p / d;
    if (p < 0 && q * d != p) q = q - 1;
    q = q + m_bias[i];
    if (q > 511) q = 511;
    if (q < -512) q = -512;
    return q;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SIZE; i++) begin
      m_scale[i] = 1 << NFRAC;
      m_bias[i]  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int a, input int s, input int b);
    coef_wr_en = 1'b1;
    coef_addr  = AW'(a);
    coef_scale = CW'(s);
    coef_bias  = WIDTH'(b);
    tick();
    coef_wr_en = 1'b0;
    m_scale[a] = s;
    m_bias[a]  = b;
  endtask

  task automatic send();
    for (int i = 0; i < SIZE; i++) in_data[i] = WIDTH'(xv[i]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check(tag, n, LAT);
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < SIZE; i++)
      check(tag, out_data[i], model(xv[i], i));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("back_to_idle", in_ready, 1);
    check("valid_drop", out_valid, 0);
  endtask

  task automatic rand_x();
    for (int i = 0; i < SIZE; i++)
      xv[i] = int'($urandom_range(0, 1023)) - 512;
  endtask

  initial begin
    int seen;
    model_reset();
    for (int i = 0; i < SIZE; i++) in_data[i] = '0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    for (int i = 0; i < SIZE; i++) check("rst_out_zero", out_data[i], 0);
    #10 rst_n = 1'b1;
    tick();

    // identity after reset
    for (int i = 0; i < SIZE; i++) xv[i] = 64;
    send();
    check("busy_in_ready", in_ready, 0);
    wait_done("lat_identity");
    check_out("identity");
    release_out();

    // scale/bias on one element
    wr_coef(3, 48, 16);
    for (int i = 0; i < SIZE; i++) xv[i] = 10 * i - 100;
    xv[3] = 64;
    send();
    wait_done("lat_elem3");
    check("elem3", out_data[3], 112);
    check_out("elem3_vec");
    release_out();

    // saturation and floor
    wr_coef(0, 64, 0);
    wr_coef(1, 64, 0);
    wr_coef(2, 16, 0);
    for (int i = 0; i < SIZE; i++) xv[i] = i;
    xv[0] = 511;
    xv[1] = -512;
    xv[2] = -1;
    send();
    wait_done("lat_sat");
    check("sat_pos", out_data[0], 511);
    check("sat_neg", out_data[1], -512);
    check("floor", out_data[2], -1);
    check_out("sat_vec");

    // hold in DONE; a coefficient write here is ignored
    for (int c = 0; c < 10; c++) begin
      coef_wr_en = (c == 3);
      coef_addr  = AW'(4);
      coef_scale = CW'(7);
      coef_bias  = WIDTH'(100);
      tick();
      coef_wr_en = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_d0", out_data[0], 511);
    end
    check_out("hold_vec");
    release_out();

    for (int i = 0; i < SIZE; i++) xv[i] = 64;
    send();
    wait_done("lat_ignored");
    check("ignored_wr", out_data[4], model(64, 4));
    check_out("ignored_vec");
    release_out();

    // randomized coefficients and data
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 8; j++)
        wr_coef(int'($urandom_range(0, SIZE - 1)),
                int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 1023)) - 512);
      rand_x();
      send();
      wait_done("lat_rand");
      check_out("rand");
      release_out();
    end

    // coefficient write on the accepting edge applies to that vector
    rand_x();
    for (int i = 0; i < SIZE; i++) in_data[i] = WIDTH'(xv[i]);
    coef_wr_en = 1'b1;
    coef_addr  = AW'(9);
    coef_scale = CW'(-40);
    coef_bias  = WIDTH'(33);
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    coef_wr_en = 1'b0;
    m_scale[9] = -40;
    m_bias[9]  = 33;
    wait_done("lat_same_edge");
    check("same_edge", out_data[9], model(xv[9], 9));
    check_out("same_edge_vec");
    release_out();

    // reset in the middle of RUN
    rand_x();
    send();
    for (int c = 0; c < 5; c++) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    for (int i = 0; i < SIZE; i++) check("mid_rst_zero", out_data[i], 0);
    #1 rst_n = 1'b1;
    model_reset();
    seen = 0;
    for (int c = 0; c < LAT + 8; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("no_valid_after_rst", seen, 0);
    rand_x();
    send();
    wait_done("lat_post_rst");
    check_out("post_rst_identity");
    release_out();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
